serial_subtractor: RTL and testbench

Bit-serial two's-complement subtractor for the ULA. It computes diff = a - b one bit per clock, LSB first, using a registered borrow flip-flop. The block is the subtract-direction counterpart of the adder cells. It trades latency for area and signals completion with a start/busy/done handshake to the ULA control logic.

---
 rtl/serial_subtractor.sv | 175 +++++++++++++++++
 tb/tb_serial_subtractor.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = a - b (mod 2^WIDTH).
// It processes one bit per clock, LSB first, and keeps the borrow in a
// flip-flop. A start/busy/done handshake runs the operation.
//
// Ports:
//   clk    - system clock, rising-edge active
//   rst_n  - asynchronous active-low reset
//   start  - request; only sampled while IDLE
//   a, b   - minuend / subtrahend; captured on the edge that accepts start
//   busy   - high while in RUN
//   done   - one-cycle pulse while in DONE
//   diff   - registered result a - b
//   borrow - unsigned borrow out (a < b unsigned)
//   zero   - diff == 0
//   neg    - diff[WIDTH-1]
//   ovf    - signed overflow of the subtraction
// -----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] r_sr_r;
    logic             bw_r;
    logic [CW-1:0]    cnt_r;
    logic             a_msb_r;
    logic             b_msb_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_r;
    logic             zero_r;
    logic             neg_r;
    logic             ovf_r;

    logic             d_s;
    logic             bw_next_s;
    logic [WIDTH-1:0] r_next_s;
    logic             last_s;

    // Signed overflow of a - b: operands differ in sign and the result's sign
    // does not follow the minuend.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                     input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    // Full-subtractor cell for the current bit and the shifted result.
    always_comb begin
        d_s       = a_sr_r[0] ^ b_sr_r[0] ^ bw_r;
        bw_next_s = (~a_sr_r[0] & b_sr_r[0]) | (~(a_sr_r[0] ^ b_sr_r[0]) & bw_r);
        r_next_s  = {d_s, r_sr_r[WIDTH-1:1]};
        last_s    = (state_r == RUN) && (cnt_r == LAST_BIT);
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, serial datapath and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_r   <= '0;
            b_sr_r   <= '0;
            r_sr_r   <= '0;
            bw_r     <= 1'b0;
            cnt_r    <= '0;
            a_msb_r  <= 1'b0;
            b_msb_r  <= 1'b0;
            diff_r   <= '0;
            borrow_r <= 1'b0;
            zero_r   <= 1'b0;
            neg_r    <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_sr_r  <= a;
                        b_sr_r  <= b;
                        r_sr_r  <= '0;
                        bw_r    <= 1'b0;
                        cnt_r   <= '0;
                        a_msb_r <= a[WIDTH-1];
                        b_msb_r <= b[WIDTH-1];
                    end
                end
                RUN: begin
                    a_sr_r <= {1'b0, a_sr_r[WIDTH-1:1]};
                    b_sr_r <= {1'b0, b_sr_r[WIDTH-1:1]};
                    r_sr_r <= r_next_s;
                    bw_r   <= bw_next_s;
                    cnt_r  <= cnt_r + CNT_ONE;
                    // Results only move on the final bit, so they hold
                    // through IDLE and any later RUN.
                    if (last_s) begin
                        diff_r   <= r_next_s;
                        borrow_r <= bw_next_s;
                        zero_r   <= (r_next_s == '0);
                        neg_r    <= d_s;
                        ovf_r    <= sub_ovf(a_msb_r, b_msb_r, d_s);
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    assign busy   = (state_r == RUN);
    assign done   = (state_r == DONE);
    assign diff   = diff_r;
    assign borrow = borrow_r;
    assign zero   = zero_r;
    assign neg    = neg_r;
    assign ovf    = ovf_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Directed-vector bench for serial_subtractor (WIDTH = 8). Expected results and
// flags are hand-computed constants. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             zero;
    logic             neg;
    logic             ovf;

    int n_checks;
    int n_pass;

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow),
        .zero   (zero),
        .neg    (neg),
        .ovf    (ovf)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One full operation. ef = {borrow, zero, neg, ovf}. prev is the result
    // that must stay on diff while the operation runs. With reassert set, a
    // second request (a=b=0xFF) is raised during RUN cycle 3 and must be ignored.
    task automatic do_op(input string tag, input logic [7:0] ta,
                         input logic [7:0] tb_v, input logic [7:0] ed,
                         input logic [3:0] ef, input logic [7:0] prev,
                         input bit reassert);
        int busy_cnt;
        int done_cnt;
        int done_at;
        int hold_bad;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        hold_bad = 0;
        @(negedge clk);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 8'hA5;
        b     = 8'h5A;
        // Falling edge k lies in the cycle after rising edge k-1.
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (reassert && k == 3) begin
                start = 1'b1;
                a     = 8'hFF;
                b     = 8'hFF;
            end else if (reassert && k == 4) begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = k;
            end
            if (k <= WIDTH && diff !== prev) hold_bad++;
        end
        check_val({tag, " busy_cycles"}, busy_cnt, 32'd8);
        check_val({tag, " done_pulses"}, done_cnt, 32'd1);
        check_val({tag, " done_timing"}, done_at, 32'd9);
        check_val({tag, " hold_prev"}, hold_bad, 32'd0);
        check_val({tag, " diff"}, {24'd0, diff}, {24'd0, ed});
        check_val({tag, " flags"}, {28'd0, borrow, zero, neg, ovf}, {28'd0, ef});
    endtask

    initial begin
        int done_cnt;
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = 8'h00;
        b        = 8'h00;
        #1;
        check_val("reset outputs", {18'd0, busy, done, diff, borrow, zero, neg, ovf},
                  32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_val("idle after reset", {30'd0, busy, done}, 32'd0);

        do_op("sub05_03", 8'h05, 8'h03, 8'h02, 4'b0000, 8'h00, 1'b0);
        do_op("sub03_05", 8'h03, 8'h05, 8'hFE, 4'b1010, 8'h02, 1'b0);
        do_op("sub80_01", 8'h80, 8'h01, 8'h7F, 4'b0001, 8'hFE, 1'b0);
        do_op("sub7F_FF", 8'h7F, 8'hFF, 8'h80, 4'b1011, 8'h7F, 1'b0);
        do_op("sub2A_2A", 8'h2A, 8'h2A, 8'h00, 4'b0100, 8'h80, 1'b0);
        do_op("ignore_start", 8'h10, 8'h01, 8'h0F, 4'b0000, 8'h00, 1'b1);

        // Asynchronous reset in the middle of RUN cycle 4.
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h01;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        check_val("busy before abort", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort outputs", {18'd0, busy, done, diff, borrow, zero, neg, ovf},
                  32'd0);
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            if (done) done_cnt++;
        end
        check_val("abort no_done", done_cnt, 32'd0);
        check_val("abort diff_kept0", {24'd0, diff}, 32'd0);

        do_op("sub09_04", 8'h09, 8'h04, 8'h05, 4'b0000, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
